goofy_io_responder: RTL and testbench

//   Target side of the core's IO bus: decodes the core's IO read/write strobes to a
//   4-register window and services them. Bytes written by the core go into a TX FIFO

---
 rtl/goofy_io_pkg.sv | 46 ++++
 rtl/goofy_io_fifo.sv | 79 +++++++
 rtl/goofy_io_responder.sv | 146 ++++++++++++++
 tb/tb_goofy_io_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goofy_io_pkg.sv
// Shared definitions for the goofy IO responder.
// Register offsets within the 4-byte window, STATUS bit positions, sticky-bit
// positions and a helper that assembles the STATUS byte.
package goofy_io_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_TXCNT  = 2'd2,
        REG_RXCNT  = 2'd3
    } reg_off_e;

    // STATUS register bit positions
    localparam int unsigned STAT_TX_FULL      = 0;
    localparam int unsigned STAT_TX_EMPTY     = 1;
    localparam int unsigned STAT_RX_EMPTY     = 2;
    localparam int unsigned STAT_RX_FULL      = 3;
    localparam int unsigned STAT_TX_OVERFLOW  = 4;
    localparam int unsigned STAT_RX_UNDERFLOW = 5;
    localparam int unsigned STAT_RX_OVERRUN   = 6;

    // Sticky vector layout: bit i maps to STATUS bit STAT_TX_OVERFLOW + i
    localparam int unsigned STK_TX_OVERFLOW  = 0;
    localparam int unsigned STK_RX_UNDERFLOW = 1;
    localparam int unsigned STK_RX_OVERRUN   = 2;

    function automatic logic [7:0] pack_status(
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_empty,
        input logic       rx_full,
        input logic [2:0] sticky
    );
        logic [7:0] s;
        s                    = 8'h00;
        s[STAT_TX_FULL]      = tx_full;
        s[STAT_TX_EMPTY]     = tx_empty;
        s[STAT_RX_EMPTY]     = rx_empty;
        s[STAT_RX_FULL]      = rx_full;
        s[STAT_TX_OVERFLOW]  = sticky[STK_TX_OVERFLOW];
        s[STAT_RX_UNDERFLOW] = sticky[STK_RX_UNDERFLOW];
        s[STAT_RX_OVERRUN]   = sticky[STK_RX_OVERRUN];
        return s;
    endfunction

endpackage

// File: rtl/goofy_io_fifo.sv
// Synchronous FIFO used for both TX and RX paths of the IO responder.
// A push while full is still accepted when a pop happens in the same cycle.
// Ports:
//   clk, res        clock, asynchronous active-low reset
//   i_push, i_din   write request and data
//   i_pop           read request (ignored when empty)
//   o_dout          head entry, 0 when empty
//   o_full/o_empty  occupancy flags
//   o_count         occupancy 0..DEPTH
//   o_drop          push request that was refused this cycle
module goofy_io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // Full FIFO can still take a byte if a slot frees up on the same edge
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Masking keeps the head at zero after reset and whenever nothing is queued
    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/goofy_io_responder.sv
// IO-bus target: decodes the core's IO strobes onto a 4-register window.
// DATA writes feed a TX FIFO drained over valid/ready; a no-backpressure source
// fills an RX FIFO popped by DATA reads. STATUS carries flags and W1C sticky errors.
// Ports:
//   clk, res                 clock, asynchronous active-low reset
//   io_addr/io_wr/io_wdata   core write access
//   io_rd/io_rdata           core read access, registered data
//   tx_valid/tx_data/tx_ready  console sink handshake
//   rx_strobe/rx_data        keyboard-style source
//   irq                      RX not empty or any sticky error set
module goofy_io_responder
    import goofy_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned RX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] io_addr,
    input  logic        io_wr,
    input  logic [7:0]  io_wdata,
    input  logic        io_rd,
    output logic [7:0]  io_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_data,
    output logic        irq
);

    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

    logic                w_sel;
    reg_off_e            w_off;
    logic                w_wr_data;
    logic                w_wr_stat;
    logic                w_rd_data;

    logic                w_tx_full;
    logic                w_tx_empty;
    logic [TX_CNT_W-1:0] w_tx_count;
    logic                w_tx_drop;
    logic                w_tx_pop;

    logic [7:0]          w_rx_dout;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic [RX_CNT_W-1:0] w_rx_count;
    logic                w_rx_drop;

    logic [2:0]          r_sticky;
    logic [2:0]          w_sticky_set;
    logic [2:0]          w_sticky_clr;

    logic [7:0]          r_rdata;
    logic [7:0]          w_rd_val;

    assign w_sel     = (io_addr[15:2] == BASE_ADDR[15:2]);
    assign w_off     = reg_off_e'(io_addr[1:0]);
    assign w_wr_data = w_sel && io_wr && (w_off == REG_DATA);
    assign w_wr_stat = w_sel && io_wr && (w_off == REG_STATUS);
    assign w_rd_data = w_sel && io_rd && (w_off == REG_DATA);

    assign tx_valid  = !w_tx_empty;
    assign w_tx_pop  = tx_valid && tx_ready;

    goofy_io_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .res     (res),
        .i_push  (w_wr_data),
        .i_din   (io_wdata),
        .i_pop   (w_tx_pop),
        .o_dout  (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count),
        .o_drop  (w_tx_drop)
    );

    goofy_io_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .res     (res),
        .i_push  (rx_strobe),
        .i_din   (rx_data),
        .i_pop   (w_rd_data),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count),
        .o_drop  (w_rx_drop)
    );

    always_comb begin
        w_sticky_set                   = '0;
        w_sticky_set[STK_TX_OVERFLOW]  = w_tx_drop;
        w_sticky_set[STK_RX_UNDERFLOW] = w_rd_data && w_rx_empty;
        w_sticky_set[STK_RX_OVERRUN]   = w_rx_drop;

        w_sticky_clr = '0;
        if (w_wr_stat) begin
            w_sticky_clr[STK_TX_OVERFLOW]  = io_wdata[STAT_TX_OVERFLOW];
            w_sticky_clr[STK_RX_UNDERFLOW] = io_wdata[STAT_RX_UNDERFLOW];
            w_sticky_clr[STK_RX_OVERRUN]   = io_wdata[STAT_RX_OVERRUN];
        end
    end

    // Read mux sees pre-edge state, so same-cycle updates are not visible
    always_comb begin
        w_rd_val = 8'h00;
        if (w_sel) begin
            unique case (w_off)
                REG_DATA:   w_rd_val = w_rx_dout;
                REG_STATUS: w_rd_val = pack_status(w_tx_full, w_tx_empty, w_rx_empty,
                                                   w_rx_full, r_sticky);
                REG_TXCNT:  w_rd_val = 8'(w_tx_count);
                REG_RXCNT:  w_rd_val = 8'(w_rx_count);
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_sticky <= '0;
            r_rdata  <= 8'h00;
        end else begin
            // Set wins over a simultaneous write-1-to-clear
            r_sticky <= (r_sticky & ~w_sticky_clr) | w_sticky_set;
            if (io_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign io_rdata = r_rdata;
    assign irq      = !w_rx_empty || (|r_sticky);

endmodule

// File: tb/tb_goofy_io_responder.sv
module tb_goofy_io_responder;

    localparam int DEPTH = 8;

    logic        clk;
    logic        res;
    logic [15:0] io_addr;
    logic        io_wr;
    logic [7:0]  io_wdata;
    logic        io_rd;
    logic [7:0]  io_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_strobe;
    logic [7:0]  rx_data;
    logic        irq;

    goofy_io_responder #(
        .BASE_ADDR (16'hFF00),
        .TX_DEPTH  (DEPTH),
        .RX_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .res       (res),
        .io_addr   (io_addr),
        .io_wr     (io_wr),
        .io_wdata  (io_wdata),
        .io_rd     (io_rd),
        .io_rdata  (io_rdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_strobe (rx_strobe),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain queues plus three sticky flags
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_tov, m_run, m_rov;
    logic [7:0] m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s[0] = (tx_q.size() == DEPTH);
        s[1] = (tx_q.size() == 0);
        s[2] = (rx_q.size() == 0);
        s[3] = (rx_q.size() == DEPTH);
        s[4] = m_tov;
        s[5] = m_run;
        s[6] = m_rov;
        s[7] = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_tov   = 0;
        m_run   = 0;
        m_rov   = 0;
        m_rdata = 8'h00;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_txv"}, tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) check_eq({tag, "_txd"}, tx_data, tx_q[0]);
        check_eq({tag, "_irq"}, irq, (rx_q.size() != 0) || m_tov || m_run || m_rov);
        check_eq({tag, "_rdata"}, io_rdata, m_rdata);
    endtask

    // One bus cycle: drive, advance model, clock, then compare everything
    task automatic cycle(input string tag, input logic [15:0] a, input bit wr,
                         input logic [7:0] wd, input bit rd, input bit txr,
                         input bit rxs, input logic [7:0] rxd);
        bit         sel;
        logic [1:0] off;
        logic [7:0] rv;
        bit         set_tov, set_run, set_rov;
        io_addr   = a;
        io_wr     = wr;
        io_wdata  = wd;
        io_rd     = rd;
        tx_ready  = txr;
        rx_strobe = rxs;
        rx_data   = rxd;

        sel = (a[15:2] == 14'h3FC0);
        off = a[1:0];
        rv  = 8'h00;
        if (sel) begin
            case (off)
                2'd0: rv = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
                2'd1: rv = model_status();
                2'd2: rv = 8'(tx_q.size());
                default: rv = 8'(rx_q.size());
            endcase
        end
        set_tov = 0;
        set_run = 0;
        set_rov = 0;
        if (txr && tx_q.size() != 0) void'(tx_q.pop_front());
        if (sel && wr && off == 2'd0) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(wd);
            else set_tov = 1;
        end
        if (sel && rd && off == 2'd0) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else set_run = 1;
        end
        if (rxs) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(rxd);
            else set_rov = 1;
        end
        if (sel && wr && off == 2'd1) begin
            if (wd[4]) m_tov = 0;
            if (wd[5]) m_run = 0;
            if (wd[6]) m_rov = 0;
        end
        m_tov = m_tov | set_tov;
        m_run = m_run | set_run;
        m_rov = m_rov | set_rov;
        if (rd) m_rdata = rv;

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic wr_io(input string tag, input logic [15:0] a, input logic [7:0] d,
                         input bit txr);
        cycle(tag, a, 1, d, 0, txr, 0, 8'h00);
    endtask

    task automatic rd_io(input string tag, input logic [15:0] a, input bit txr);
        cycle(tag, a, 0, 8'h00, 1, txr, 0, 8'h00);
    endtask

    task automatic idle(input string tag, input bit txr);
        cycle(tag, 16'h0000, 0, 8'h00, 0, txr, 0, 8'h00);
    endtask

    initial begin
        logic [15:0] a;
        res       = 1'b0;
        io_addr   = 16'h0000;
        io_wr     = 1'b0;
        io_wdata  = 8'h00;
        io_rd     = 1'b0;
        tx_ready  = 1'b0;
        rx_strobe = 1'b0;
        rx_data   = 8'h00;
        model_reset();

        #2;
        check_eq("rst_txv", tx_valid, 0);
        check_eq("rst_txd", tx_data, 8'h00);
        check_eq("rst_rdata", io_rdata, 8'h00);
        check_eq("rst_irq", irq, 0);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);

        // 1: two bytes queued, then drained in order
        wr_io("t1_w", 16'hFF00, 8'h41, 0);
        wr_io("t1_w", 16'hFF00, 8'h42, 0);
        rd_io("t1_r", 16'hFF02, 0);
        check_eq("t1_txcnt", io_rdata, 8'd2);
        check_eq("t1_head", tx_data, 8'h41);
        idle("t1_d", 1);
        check_eq("t1_beat2", tx_data, 8'h42);
        idle("t1_d", 1);
        check_eq("t1_txv_drop", tx_valid, 0);
        rd_io("t1_s", 16'hFF01, 0);
        check_eq("t1_tx_empty", io_rdata[1], 1);

        // 2: overflow on the ninth write, W1C, head preserved
        for (int i = 0; i < 9; i++) wr_io("t2_w", 16'hFF00, 8'(i + 1), 0);
        rd_io("t2_s", 16'hFF01, 0);
        check_eq("t2_full_ovf", io_rdata & 8'h13, 8'h11);
        wr_io("t2_clr", 16'hFF01, 8'h10, 0);
        rd_io("t2_s2", 16'hFF01, 0);
        check_eq("t2_ovf_clr", io_rdata[4], 0);
        check_eq("t2_head", tx_data, 8'h01);
        for (int i = 0; i < DEPTH; i++) idle("t2_d", 1);

        // 3: RX path with underflow
        cycle("t3_s", 16'h0000, 0, 8'h00, 0, 0, 1, 8'h55);
        cycle("t3_s", 16'h0000, 0, 8'h00, 0, 0, 1, 8'hAA);
        check_eq("t3_irq", irq, 1);
        rd_io("t3_cnt", 16'hFF03, 0);
        check_eq("t3_rxcnt", io_rdata, 8'd2);
        rd_io("t3_r1", 16'hFF00, 0);
        check_eq("t3_r1v", io_rdata, 8'h55);
        rd_io("t3_r2", 16'hFF00, 0);
        check_eq("t3_r2v", io_rdata, 8'hAA);
        rd_io("t3_r3", 16'hFF00, 0);
        check_eq("t3_r3v", io_rdata, 8'h00);
        rd_io("t3_s", 16'hFF01, 0);
        check_eq("t3_unf", io_rdata[5], 1);
        check_eq("t3_irq_hold", irq, 1);
        wr_io("t3_clr", 16'hFF01, 8'h20, 0);
        check_eq("t3_irq_clr", irq, 0);

        // 4: full RX with simultaneous pop/push, then overrun
        for (int i = 0; i < DEPTH; i++) cycle("t4_f", 16'h0000, 0, 8'h00, 0, 0, 1, 8'(8'hC0 + i));
        cycle("t4_rp", 16'hFF00, 0, 8'h00, 1, 0, 1, 8'h99);
        check_eq("t4_oldest", io_rdata, 8'hC0);
        rd_io("t4_s", 16'hFF01, 0);
        check_eq("t4_no_ovr", io_rdata[6], 0);
        cycle("t4_ovr", 16'h0000, 0, 8'h00, 0, 0, 1, 8'h5A);
        rd_io("t4_s2", 16'hFF01, 0);
        check_eq("t4_ovr_set", io_rdata[6], 1);
        rd_io("t4_cnt", 16'hFF03, 0);
        check_eq("t4_rxcnt", io_rdata, 8'd8);
        wr_io("t4_clr", 16'hFF01, 8'h70, 0);
        for (int i = 0; i < DEPTH; i++) rd_io("t4_dr", 16'hFF00, 0);
        check_eq("t4_last", io_rdata, 8'h99);

        // 5: outside the window
        wr_io("t5_w", 16'h1234, 8'h77, 0);
        rd_io("t5_r", 16'h1234, 0);
        check_eq("t5_rd0", io_rdata, 8'h00);
        check_eq("t5_txv", tx_valid, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0: a = 16'h1234;
                1: a = 16'($urandom);
                2: a = 16'hFF04 + 16'($urandom_range(0, 3));
                default: a = 16'hFF00 + 16'($urandom_range(0, 3));
            endcase
            cycle("rnd", a, $urandom_range(0, 9) < 3, 8'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, 8'($urandom));
        end

        // 6: asynchronous reset mid-drain
        for (int i = 0; i < DEPTH + 2; i++) idle("t6_d", 1);
        for (int i = 0; i < 5; i++) wr_io("t6_w", 16'hFF00, 8'(8'hE0 + i), 0);
        idle("t6_p", 1);
        idle("t6_p", 1);
        rd_io("t6_cnt", 16'hFF02, 0);
        check_eq("t6_txcnt", io_rdata, 8'd3);
        tx_ready = 1'b1;
        #2;
        res = 1'b0;
        #1;
        check_eq("t6_txv", tx_valid, 0);
        check_eq("t6_rdata", io_rdata, 8'h00);
        check_eq("t6_irq", irq, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("t6_hold");
        @(negedge clk);
        res = 1'b1;
        rd_io("t6_s", 16'hFF01, 0);
        check_eq("t6_status", io_rdata, 8'h06);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
